// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the memory bus arbiter slice. It holds the bus command
//   encoding, the load-tag owner enum, the tag-table entry struct and the
//   bus width constants.
package mem_bus_arbiter_pkg;

    localparam int SYS_XLEN = 32;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 15;   // tags 1..15; tag 0 means "none"

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the icache, dcache and memory-side signals of the arbiter.
//   slave  : the arbiter's view. It receives the cache requests and the
//            memory responses, and it drives the bus and the cache responses.
//   master : the environment's view. This covers the caches and the memory model.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    // icache port
    BUS_COMMAND           icache_mem_req_cmd;
    logic [SYS_XLEN-1:0]  icache_mem_req_addr;
    logic [TAG_W-1:0]     icache_mem_resp_code;
    logic [63:0]          icache_mem_resp_data;
    logic [TAG_W-1:0]     icache_mem_resp_id;
    logic                 mc_ic_hold_flag;
    // dcache port
    BUS_COMMAND           dcache_mem_req_cmd;
    logic [SYS_XLEN-1:0]  dcache_mem_req_addr;
    logic [63:0]          dcache_mem_req_data;
    logic [TAG_W-1:0]     dcache_mem_resp_code;
    logic [63:0]          dcache_mem_resp_data;
    logic [TAG_W-1:0]     dcache_mem_resp_id;
    logic                 mc_dc_hold_flag;
    // memory port
    BUS_COMMAND           mem_req_cmd;
    logic [SYS_XLEN-1:0]  mem_req_addr;
    logic [63:0]          mem_req_data;
    logic [TAG_W-1:0]     mem_resp_code;
    logic [63:0]          mem_resp_data;
    logic [TAG_W-1:0]     mem_resp_id;
    // status
    logic [TAG_W-1:0]     arb_out_cnt;
    logic                 arb_tag_err;

    modport slave (
        input  icache_mem_req_cmd, icache_mem_req_addr,
        input  dcache_mem_req_cmd, dcache_mem_req_addr, dcache_mem_req_data,
        input  mem_resp_code, mem_resp_data, mem_resp_id,
        output mem_req_cmd, mem_req_addr, mem_req_data,
        output icache_mem_resp_code, icache_mem_resp_data, icache_mem_resp_id, mc_ic_hold_flag,
        output dcache_mem_resp_code, dcache_mem_resp_data, dcache_mem_resp_id, mc_dc_hold_flag,
        output arb_out_cnt, arb_tag_err
    );

    modport master (
        output icache_mem_req_cmd, icache_mem_req_addr,
        output dcache_mem_req_cmd, dcache_mem_req_addr, dcache_mem_req_data,
        output mem_resp_code, mem_resp_data, mem_resp_id,
        input  mem_req_cmd, mem_req_addr, mem_req_data,
        input  icache_mem_resp_code, icache_mem_resp_data, icache_mem_resp_id, mc_ic_hold_flag,
        input  dcache_mem_resp_code, dcache_mem_resp_data, dcache_mem_resp_id, mc_dc_hold_flag,
        input  arb_out_cnt, arb_tag_err
    );

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// mem_tag_table
//   Outstanding-load tag table. It has one {valid, owner} entry for each tag 1..15.
//   Ports:
//     clk, rst              clock, synchronous active-high reset (clears all entries)
//     set_en/tag/owner      allocate a tag at the clock edge
//     clr_en/tag            retire a tag at the clock edge (set wins on same tag)
//     lk_tag -> lk_valid/   combinational lookup of an entry's state before the edge
//               lk_owner
//     cnt                   popcount of valid entries (function of flops only)
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  MEM_OWNER         set_owner,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             lk_valid,
    output MEM_OWNER         lk_owner,
    output logic [TAG_W-1:0] cnt
);

    // Entry 0 exists only so that a 4-bit tag always indexes in range. It is never set.
    MEM_TAG_ENTRY tbl [0:NUM_TAGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_TAGS; i++) tbl[i] <= '0;
        end else begin
            if (clr_en && clr_tag != '0) tbl[clr_tag].valid <= 1'b0;
            // The set comes after the clear, so a tag that is retired and re-issued in one cycle stays valid.
            if (set_en && set_tag != '0) tbl[set_tag] <= '{valid: 1'b1, owner: set_owner};
        end
    end

    always_comb begin
        lk_valid = (lk_tag != '0) && tbl[lk_tag].valid;
        lk_owner = tbl[lk_tag].owner;
    end

    always_comb begin
        cnt = '0;
        for (int i = 1; i <= NUM_TAGS; i++) cnt = cnt + TAG_W'(tbl[i].valid);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one tagged memory bus between the icache (loads) and the dcache
//   (loads and stores). The dcache has fixed priority. An icache that has been
//   refused STARVE_MAX times in a row is granted ahead of the dcache. Loads
//   are held off while MAX_OUT tags are outstanding. Returning load data goes
//   to whichever port owns the tag.
//   Ports:
//     clk, rst   clock, synchronous active-high reset. While reset is active,
//                every combinational output is forced to zero.
//     bus        mem_bus_arbiter_if.slave: cache requests and responses, the memory
//                bus, arb_out_cnt and arb_tag_err
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int MAX_OUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]    starve_cnt;
    logic             ic_req, dc_req, dc_is_load, load_blocked;
    logic             ic_ok, dc_ok, ic_prio, grant_ic, grant_dc, accepted;
    logic             set_en, clr_en, lk_valid, tag_err_nxt;
    MEM_OWNER         lk_owner;
    logic [TAG_W-1:0] out_cnt;

    // Arbitration
    always_comb begin
        ic_req       = !rst && bus.icache_mem_req_cmd != BUS_NONE;
        dc_req       = !rst && bus.dcache_mem_req_cmd != BUS_NONE;
        dc_is_load   = bus.dcache_mem_req_cmd == BUS_LOAD;
        load_blocked = out_cnt == TAG_W'(MAX_OUT);
        // The icache only issues loads, so a load block leaves it nothing to send.
        ic_ok        = ic_req && !load_blocked;
        dc_ok        = dc_req && !(dc_is_load && load_blocked);
        ic_prio      = starve_cnt == SW'(STARVE_MAX);
        grant_ic     = ic_ok && (ic_prio || !dc_ok);
        grant_dc     = dc_ok && !grant_ic;
        accepted     = (grant_ic || grant_dc) && bus.mem_resp_code != '0;
    end

    // Memory-side mux and the two response ports
    always_comb begin
        bus.mem_req_cmd          = BUS_NONE;
        bus.mem_req_addr         = '0;
        bus.mem_req_data         = '0;
        bus.icache_mem_resp_code = '0;
        bus.dcache_mem_resp_code = '0;
        bus.icache_mem_resp_data = '0;
        bus.icache_mem_resp_id   = '0;
        bus.dcache_mem_resp_data = '0;
        bus.dcache_mem_resp_id   = '0;
        if (grant_ic) begin
            bus.mem_req_cmd          = bus.icache_mem_req_cmd;
            bus.mem_req_addr         = bus.icache_mem_req_addr;
            bus.icache_mem_resp_code = bus.mem_resp_code;
        end else if (grant_dc) begin
            bus.mem_req_cmd          = bus.dcache_mem_req_cmd;
            bus.mem_req_addr         = bus.dcache_mem_req_addr;
            bus.mem_req_data         = bus.dcache_mem_req_data;
            bus.dcache_mem_resp_code = bus.mem_resp_code;
        end
        // Lookup sees the pre-edge owner, so a same-cycle re-issue cannot redirect this return.
        if (!rst && lk_valid) begin
            if (lk_owner == OWN_IC) begin
                bus.icache_mem_resp_data = bus.mem_resp_data;
                bus.icache_mem_resp_id   = bus.mem_resp_id;
            end else begin
                bus.dcache_mem_resp_data = bus.mem_resp_data;
                bus.dcache_mem_resp_id   = bus.mem_resp_id;
            end
        end
        bus.mc_ic_hold_flag = ic_req && !grant_ic;
        bus.mc_dc_hold_flag = dc_req && !grant_dc;
    end

    always_comb begin
        set_en      = !rst && accepted && bus.mem_req_cmd == BUS_LOAD;
        clr_en      = !rst && lk_valid;
        tag_err_nxt = !rst && bus.mem_resp_id != '0 && !lk_valid;
    end

    mem_tag_table u_tag_table (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_tag   (bus.mem_resp_code),
        .set_owner (grant_ic ? OWN_IC : OWN_DC),
        .clr_en    (clr_en),
        .clr_tag   (bus.mem_resp_id),
        .lk_tag    (bus.mem_resp_id),
        .lk_valid  (lk_valid),
        .lk_owner  (lk_owner),
        .cnt       (out_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt      <= '0;
            bus.arb_tag_err <= 1'b0;
        end else begin
            bus.arb_tag_err <= tag_err_nxt;
            if (!ic_req || (grant_ic && bus.mem_resp_code != '0))
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // The table clears on reset, so this count is already zero on the edge after reset.
    assign bus.arb_out_cnt = out_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed-vector bench for mem_bus_arbiter. Inputs change just after the
//   falling edge. Combinational outputs are checked 1 ns later. Registered
//   outputs are checked in the step after the rising edge.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.STARVE_MAX(4), .MAX_OUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge, apply one cycle of inputs, then let them settle.
    task automatic step(input BUS_COMMAND ic_cmd, input logic [31:0] ic_addr,
                        input BUS_COMMAND dc_cmd, input logic [31:0] dc_addr,
                        input logic [63:0] dc_data, input logic [3:0] code,
                        input logic [3:0] rid, input logic [63:0] rdata);
        @(negedge clk);
        bus.icache_mem_req_cmd  = ic_cmd;
        bus.icache_mem_req_addr = ic_addr;
        bus.dcache_mem_req_cmd  = dc_cmd;
        bus.dcache_mem_req_addr = dc_addr;
        bus.dcache_mem_req_data = dc_data;
        bus.mem_resp_code       = code;
        bus.mem_resp_id         = rid;
        bus.mem_resp_data       = rdata;
        #1;
    endtask

    task automatic idle();
        step(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
    endtask

    // Tags used to top the table up to 15 in test 5
    logic [3:0] fill_tags [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd12, 4'd14, 4'd15};

    initial begin
        // Reset. While reset is active, a live request must not reach memory.
        step(BUS_LOAD, 32'h1000, BUS_LOAD, 32'h2000, 0, 4'd3, 0, 0);
        chk("rst_cmd",     bus.mem_req_cmd, BUS_NONE);
        chk("rst_ic_hold", bus.mc_ic_hold_flag, 0);
        chk("rst_dc_code", bus.dcache_mem_resp_code, 0);
        idle();
        chk("rst_cnt",     bus.arb_out_cnt, 0);
        chk("rst_err",     bus.arb_tag_err, 0);
        rst = 1'b0;

        // 1: icache alone
        step(BUS_LOAD, 32'h1000, BUS_NONE, 0, 0, 4'd3, 0, 0);
        chk("t1_cmd",     bus.mem_req_cmd, BUS_LOAD);
        chk("t1_addr",    bus.mem_req_addr, 32'h1000);
        chk("t1_ic_code", bus.icache_mem_resp_code, 3);
        chk("t1_ic_hold", bus.mc_ic_hold_flag, 0);
        idle();
        chk("t1_cnt",     bus.arb_out_cnt, 1);

        // 2: both ports load, and the dcache wins
        step(BUS_LOAD, 32'h1100, BUS_LOAD, 32'h2200, 0, 4'd5, 0, 0);
        chk("t2_addr",    bus.mem_req_addr, 32'h2200);
        chk("t2_dc_code", bus.dcache_mem_resp_code, 5);
        chk("t2_ic_code", bus.icache_mem_resp_code, 0);
        chk("t2_ic_hold", bus.mc_ic_hold_flag, 1);
        chk("t2_dc_hold", bus.mc_dc_hold_flag, 0);
        idle();   // the icache drops its request here, so starvation restarts from 0
        chk("t2_cnt",     bus.arb_out_cnt, 2);

        // 3: the dcache loads on every cycle. The icache is refused 4 times, then granted.
        for (int i = 0; i < 4; i++) begin
            step(BUS_LOAD, 32'h1300, BUS_LOAD, 32'h2300, 0, 4'(8 + i), 0, 0);
            chk($sformatf("t3_ic_hold%0d", i), bus.mc_ic_hold_flag, 1);
        end
        step(BUS_LOAD, 32'h1300, BUS_LOAD, 32'h2300, 0, 4'd12, 0, 0);
        chk("t3_ic_code", bus.icache_mem_resp_code, 12);
        chk("t3_addr",    bus.mem_req_addr, 32'h1300);
        chk("t3_dc_hold", bus.mc_dc_hold_flag, 1);
        chk("t3_ic_hold", bus.mc_ic_hold_flag, 0);
        step(BUS_LOAD, 32'h1300, BUS_LOAD, 32'h2300, 0, 4'd13, 0, 0);
        chk("t3_reprio",  bus.dcache_mem_resp_code, 13);
        idle();
        chk("t3_cnt",     bus.arb_out_cnt, 8);   // tags 3,5,8,9,10,11,12,13

        // 4: return routing. Tag 3 belongs to the icache and tag 7 to the dcache.
        step(BUS_NONE, 0, BUS_LOAD, 32'h2400, 0, 4'd7, 0, 0);
        step(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd7, 64'hABCD);
        chk("t4_cnt_pre", bus.arb_out_cnt, 9);
        chk("t4_dc_id",   bus.dcache_mem_resp_id, 7);
        chk("t4_dc_data", bus.dcache_mem_resp_data, 64'hABCD);
        chk("t4_ic_id",   bus.icache_mem_resp_id, 0);
        step(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd3, 64'h1234);
        chk("t4_cnt_mid", bus.arb_out_cnt, 8);
        chk("t4_ic_id3",  bus.icache_mem_resp_id, 3);
        chk("t4_ic_dat3", bus.icache_mem_resp_data, 64'h1234);
        chk("t4_dc_id3",  bus.dcache_mem_resp_id, 0);
        // Tag 12 returns to the icache while the dcache re-issues tag 12.
        step(BUS_NONE, 0, BUS_LOAD, 32'h2500, 0, 4'd12, 4'd12, 64'h55);
        chk("t4_cnt_post", bus.arb_out_cnt, 7);
        chk("t4_same_ic", bus.icache_mem_resp_id, 12);
        chk("t4_same_dc", bus.dcache_mem_resp_id, 0);
        step(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd12, 64'h66);
        chk("t4_same_cnt", bus.arb_out_cnt, 7);
        chk("t4_new_own", bus.dcache_mem_resp_id, 12);
        idle();
        chk("t4_cnt_end", bus.arb_out_cnt, 6);

        // 5: fill the table to 15 entries. After that, loads are blocked and stores still pass.
        foreach (fill_tags[i]) step(BUS_NONE, 0, BUS_LOAD, 32'h2600, 0, fill_tags[i], 0, 0);
        step(BUS_LOAD, 32'h1500, BUS_LOAD, 32'h2700, 0, 4'd1, 0, 0);
        chk("t5_cnt",     bus.arb_out_cnt, 15);
        chk("t5_cmd",     bus.mem_req_cmd, BUS_NONE);
        chk("t5_dc_hold", bus.mc_dc_hold_flag, 1);
        chk("t5_ic_hold", bus.mc_ic_hold_flag, 1);
        chk("t5_dc_code", bus.dcache_mem_resp_code, 0);
        step(BUS_NONE, 0, BUS_STORE, 32'h2800, 64'hFEED, 4'd2, 0, 0);
        chk("t5_st_cmd",  bus.mem_req_cmd, BUS_STORE);
        chk("t5_st_data", bus.mem_req_data, 64'hFEED);
        chk("t5_st_code", bus.dcache_mem_resp_code, 2);
        chk("t5_st_hold", bus.mc_dc_hold_flag, 0);
        idle();
        chk("t5_st_cnt",  bus.arb_out_cnt, 15);

        // 6: reset in mid-operation. A tag from before the reset comes back as an error.
        rst = 1'b1;
        idle();
        rst = 1'b0;
        step(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'd3, 64'h77);
        chk("t6_cnt",     bus.arb_out_cnt, 0);
        chk("t6_ic_id",   bus.icache_mem_resp_id, 0);
        chk("t6_dc_id",   bus.dcache_mem_resp_id, 0);
        chk("t6_err_pre", bus.arb_tag_err, 0);
        idle();
        chk("t6_err",     bus.arb_tag_err, 1);
        idle();
        chk("t6_err_end", bus.arb_tag_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
